mult_25x35_parallel_pipe: RTL and testbench

Fully pipelined signed 25×35-bit multiplier producing a full-precision 60-bit product, one result per clock. It is built as two parallel DSP48E-style 25×18 partial-product slices whose results are combined through a 17-bit-shifted cascade add. It is used wherever the datapath needs a multiplier wider than one DSP slice, at DSP-slice clock rates, with fixed latency and no handshake.

---
 rtl/mult_25x35_parallel_pipe_if.sv | 10 +
 rtl/mult_25x35_parallel_pipe.sv | 53 +++++
 tb/tb_mult_25x35_parallel_pipe.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mult_25x35_parallel_pipe_if.sv
// Operand/product bundle for the 25x35 signed pipelined multiplier.
// There is no handshake: a new operand pair is taken on every clock edge.
interface mult_25x35_parallel_pipe_if;
    logic [24:0] A_IN;
    logic [34:0] B_IN;
    logic [59:0] PROD_OUT;

    modport master (output A_IN, output B_IN, input PROD_OUT);
    modport slave  (input A_IN, input B_IN, output PROD_OUT);
endinterface

// File: rtl/mult_25x35_parallel_pipe.sv
// Signed 25x35 -> 60-bit multiplier built from two 25x18 slices joined by a
// 17-bit-shifted cascade add; four-edge fixed latency, one result per clock.
module mult_25x35_parallel_pipe (
    input  logic                         CLK,
    input  logic                         RST,
    mult_25x35_parallel_pipe_if.slave    bus
);

    logic signed [24:0] a1_q, a2_q;
    logic        [34:0] b1_q;
    logic signed [17:0] bhi2_q;
    logic signed [42:0] ml_q, pl_q, mh_q;
    logic        [59:0] prod_q;

    logic signed [17:0] blo_s;
    logic signed [42:0] ml_d, mh_d, ph_d;
    logic        [59:0] prod_d;

    // Slice products are kept at 43 bits: a 25x18 signed product never needs
    // more, and the upper bits of a 48-bit slice output would be pure sign.
    always_comb begin
        blo_s  = signed'({1'b0, b1_q[16:0]});
        ml_d   = 43'(a1_q) * 43'(blo_s);
        mh_d   = 43'(a2_q) * 43'(bhi2_q);
        ph_d   = mh_q + (pl_q >>> 17);
        prod_d = {ph_d, pl_q[16:0]};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a1_q   <= '0;
            b1_q   <= '0;
            a2_q   <= '0;
            bhi2_q <= '0;
            ml_q   <= '0;
            pl_q   <= '0;
            mh_q   <= '0;
            prod_q <= '0;
        end else begin
            a1_q   <= signed'(bus.A_IN);
            b1_q   <= bus.B_IN;
            a2_q   <= a1_q;
            bhi2_q <= signed'(b1_q[34:17]);
            ml_q   <= ml_d;
            pl_q   <= ml_q;
            mh_q   <= mh_d;
            prod_q <= prod_d;
        end
    end

    assign bus.PROD_OUT = prod_q;

endmodule

// File: tb/tb_mult_25x35_parallel_pipe.sv
// Bench for mult_25x35_parallel_pipe: delay-line reference of exact signed
// products, per-cycle compare, directed literal cases and random streaming.
module tb_mult_25x35_parallel_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [59:0] model_out = '0;
    logic [59:0] exp_q[$];

    mult_25x35_parallel_pipe_if bus();

    mult_25x35_parallel_pipe dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [59:0] ref_prod(input logic [24:0] a, input logic [34:0] b);
        longint sa, sb, p;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        return p[59:0];
    endfunction

    task automatic check(input string name, input logic [59:0] act, input logic [59:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: output after edge k is the product sampled at edge k-3.
    task automatic model_flush();
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
        model_out = '0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_flush();
        end else begin
            exp_q.push_back(ref_prod(bus.A_IN, bus.B_IN));
            model_out = exp_q.pop_front();
        end
    end

    always @(negedge clk) begin
        check("pipe", bus.PROD_OUT, model_out);
    end

    task automatic drive(input logic [24:0] a, input logic [34:0] b);
        @(posedge clk);
        #1;
        bus.A_IN = a;
        bus.B_IN = b;
    endtask

    // Apply a pair, hold it, and check the literal exactly 4 edges later.
    task automatic directed(input string name, input logic [24:0] a, input logic [34:0] b,
                            input logic [59:0] exp);
        drive(a, b);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check(name, bus.PROD_OUT, exp);
        check({name, "_model"}, model_out, exp);
        repeat (2) @(posedge clk);
    endtask

    function automatic logic [34:0] rand_b();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[34:0];
    endfunction

    initial begin
        model_flush();
        bus.A_IN = 25'($urandom);
        bus.B_IN = rand_b();

        // Reset held with arbitrary inputs; the compare process expects 0.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold", bus.PROD_OUT, 60'h0);
        bus.A_IN = '0;
        bus.B_IN = '0;
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk) check("post_release", bus.PROD_OUT, 60'h0);

        directed("small_512",  25'd512,  35'd512,  60'h000000000040000);
        directed("small_2020", 25'd2020, 35'd2020, 60'h0000000003E4310);
        directed("small_10",   25'd10,   35'd10,   60'h000000000000064);
        directed("max_max",    25'd16777215, 35'd17179869183, 60'h3FFFFFBFF000001);
        directed("max_2p18",   25'd16777215, 35'd262144,      60'h000003FFFFFC0000);
        directed("min_min",    25'h1000000,  35'h400000000,   60'h400000000000000);
        directed("neg1_x2",    25'h1FFFFFF,  35'd2,           60'hFFFFFFFFFFFFFFE);
        directed("bhi_zero",   25'd3,        35'd131071,      60'd393213);
        directed("neg5_2p17",  -25'sd5,      35'd131072,      -60'sd655360);

        // Back-to-back random pairs with occasional extremes.
        for (int i = 0; i < 1200; i++) begin
            logic [24:0] a;
            logic [34:0] b;
            a = 25'($urandom);
            b = rand_b();
            if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) != 0) ? 25'h1000000 : 25'h0FFFFFF;
            if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) != 0) ? 35'h400000000 : 35'h3FFFFFFFF;
            drive(a, b);
            if (i == 600) begin
                // Short reset pulse between edges while the pipeline is full.
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1 check("async_clear", bus.PROD_OUT, 60'h0);
                #1 rst_n = 1'b1;
            end
        end

        repeat (6) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
